// File: rtl/data_path_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Define MEM_WAIT_EN to stretch MEM until mem_ready is sampled high.
module data_path_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_instr,
    input  logic        mem_ready,
    input  logic        beq,
    input  logic        bneq,
    input  logic        bge,
    input  logic        blt,
    input  logic [31:0] alu_result,
    output logic [4:0]  read_reg_num1,
    output logic [4:0]  read_reg_num2,
    output logic [4:0]  write_reg_num1,
    output logic [5:0]  alu_control,
    output logic        jump,
    output logic        beq_control,
    output logic        bne_control,
    output logic        bgeq_control,
    output logic        blt_control,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        lui_control,
    output logic [31:0] imm_val,
    output logic [31:0] imm_val_lui,
    output logic [31:0] pc,
    output logic        illegal,
    output logic [31:0] link_addr
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t      state_q;
    logic [31:0] ir_q, pc_q, link_q;
    logic        imem_req_q, illegal_q, jump_q;
    logic        beq_ctl_q, bne_ctl_q, bge_ctl_q, blt_ctl_q;
    logic        reg_write_q, mem_to_reg_q, mem_read_q, mem_write_q, lui_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal, is_jalr;
    logic        is_legal, is_jump, br_taken, mem_done;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_inc_d;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign rd      = ir_q[11:7];
    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LOAD);
    assign is_st   = (opcode == OP_STORE);
    assign is_br   = (opcode == OP_BRANCH);
    assign is_lui  = (opcode == OP_LUI);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_jump = is_jal | is_jalr;
    assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_lui | is_jump;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // funct3[2] selects the signed compares, funct3[0] the inverted sense
    assign br_taken = funct3[2] ? (funct3[0] ? bge : blt) : (funct3[0] ? bneq : beq);
    assign pc_inc_d = pc_q + 32'd4;

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    always_comb begin
        imm_val     = 32'd0;
        alu_control = 6'd0;
        alu_src     = 1'b0;
        case (opcode)
            OP_R:      alu_control = {2'b00, ir_q[30], funct3};
            OP_I: begin
                alu_src     = 1'b1;
                imm_val     = imm_i;
                alu_control = {2'b00, ir_q[30] & (funct3 == 3'b101), funct3};
            end
            OP_LOAD:   begin alu_src = 1'b1; imm_val = imm_i; end
            OP_STORE:  begin alu_src = 1'b1; imm_val = imm_s; end
            OP_BRANCH: begin imm_val = imm_b; alu_control = {3'b100, funct3}; end
            OP_LUI:    imm_val = imm_u;
            OP_JAL:    imm_val = imm_j;
            OP_JALR:   begin alu_src = 1'b1; imm_val = imm_i; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            ir_q         <= 32'd0;
            pc_q         <= 32'd0;
            link_q       <= 32'd0;
            imem_req_q   <= 1'b0;
            illegal_q    <= 1'b0;
            jump_q       <= 1'b0;
            beq_ctl_q    <= 1'b0;
            bne_ctl_q    <= 1'b0;
            bge_ctl_q    <= 1'b0;
            blt_ctl_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            lui_q        <= 1'b0;
        end else begin
            case (state_q)
                // request rises one cycle into FETCH and is held until accepted
                FETCH: begin
                    imem_req_q <= 1'b1;
                    if (imem_req_q && imem_valid) begin
                        ir_q       <= imem_instr;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    if (!is_legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= HALT;
                    end else begin
                        jump_q    <= is_jump;
                        beq_ctl_q <= is_br && (funct3 == 3'b000);
                        bne_ctl_q <= is_br && (funct3 == 3'b001);
                        blt_ctl_q <= is_br && funct3[2] && !funct3[0];
                        bge_ctl_q <= is_br && funct3[2] && funct3[0];
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    jump_q    <= 1'b0;
                    beq_ctl_q <= 1'b0;
                    bne_ctl_q <= 1'b0;
                    blt_ctl_q <= 1'b0;
                    bge_ctl_q <= 1'b0;
                    if (is_ld || is_st) begin
                        mem_read_q  <= is_ld;
                        mem_write_q <= is_st;
                        state_q     <= MEM;
                    end else if (is_br) begin
                        pc_q    <= br_taken ? (pc_q + imm_val) : pc_inc_d;
                        state_q <= FETCH;
                    end else begin
                        reg_write_q <= (rd != 5'd0);
                        lui_q       <= is_lui;
                        if (is_jump) begin
                            link_q <= pc_inc_d;
                            pc_q   <= is_jal ? (pc_q + imm_val) : (alu_result & ~32'd1);
                        end
                        state_q <= WB;
                    end
                end
                MEM: begin
                    if (mem_done) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (is_ld) begin
                            reg_write_q  <= (rd != 5'd0);
                            mem_to_reg_q <= 1'b1;
                            state_q      <= WB;
                        end else begin
                            pc_q    <= pc_inc_d;
                            state_q <= FETCH;
                        end
                    end
                end
                // jumps already redirected pc in EXEC
                WB: begin
                    reg_write_q  <= 1'b0;
                    mem_to_reg_q <= 1'b0;
                    lui_q        <= 1'b0;
                    if (!is_jump) pc_q <= pc_inc_d;
                    state_q <= FETCH;
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign read_reg_num1  = ir_q[19:15];
    assign read_reg_num2  = ir_q[24:20];
    assign write_reg_num1 = rd;
    assign imm_val_lui    = imm_u;
    assign jump           = jump_q;
    assign beq_control    = beq_ctl_q;
    assign bne_control    = bne_ctl_q;
    assign bgeq_control   = bge_ctl_q;
    assign blt_control    = blt_ctl_q;
    assign reg_write      = reg_write_q;
    assign mem_to_reg     = mem_to_reg_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign lui_control    = lui_q;
    assign illegal        = illegal_q;
    assign link_addr      = link_q;

endmodule

// File: tb/tb_data_path_ctrl.sv
// Directed bench for data_path_ctrl: one instruction at a time with hand-computed expectations.
module tb_data_path_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_valid, mem_ready;
    logic [31:0] imem_addr, imem_instr, alu_result;
    logic        beq, bneq, bge, blt;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg_num1;
    logic [5:0]  alu_control;
    logic        jump, beq_control, bne_control, bgeq_control, blt_control;
    logic        alu_src, reg_write, mem_to_reg, mem_read, mem_write, lui_control;
    logic [31:0] imm_val, imm_val_lui, pc, link_addr;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    data_path_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_instr(imem_instr),
        .mem_ready(mem_ready),
        .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
        .alu_result(alu_result),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg_num1(write_reg_num1), .alu_control(alu_control),
        .jump(jump), .beq_control(beq_control), .bne_control(bne_control),
        .bgeq_control(bgeq_control), .blt_control(blt_control),
        .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write), .lui_control(lui_control),
        .imm_val(imm_val), .imm_val_lui(imm_val_lui), .pc(pc),
        .illegal(illegal), .link_addr(link_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents instr with valid high; returns sampled in the DECODE cycle.
    task automatic fetch(input logic [31:0] instr);
        int n;
        n = 0;
        imem_instr = instr;
        imem_valid = 1'b1;
        while (!imem_req && n < 10) begin
            step();
            n++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        step();
        imem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int hi;
        rst = 1'b0; imem_valid = 1'b0; imem_instr = 32'd0; mem_ready = 1'b0;
        beq = 1'b0; bneq = 1'b0; bge = 1'b0; blt = 1'b0; alu_result = 32'd0;

        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_aluctl", 32'(alu_control), 32'd0);
        check("rst_imm", imm_val, 32'd0);
        check("rst_regwrite", 32'(reg_write), 32'd0);

        #10 rst = 1'b1;
        step();
        check("req_after_rst", 32'(imem_req), 32'd1);
        step();
        check("req_held", 32'(imem_req), 32'd1);
        check("pc_held", pc, 32'd0);

        // ADDI x1,x0,5
        fetch(32'h00500093);
        check("addi_alusrc", 32'(alu_src), 32'd1);
        check("addi_imm", imm_val, 32'd5);
        check("addi_rd", 32'(write_reg_num1), 32'd1);
        check("addi_aluctl", 32'(alu_control), 32'd0);
        check("addi_req_low", 32'(imem_req), 32'd0);
        step();
        check("addi_exec_rw", 32'(reg_write), 32'd0);
        step();
        check("addi_wb_rw", 32'(reg_write), 32'd1);
        check("addi_wb_rd", 32'(write_reg_num1), 32'd1);
        step();
        check("addi_rw_pulse", 32'(reg_write), 32'd0);
        check("addi_pc", pc, 32'd4);

        // SUB x3,x1,x2
        fetch(32'h402081B3);
        check("sub_aluctl", 32'(alu_control), 32'h08);
        check("sub_alusrc", 32'(alu_src), 32'd0);
        check("sub_rs1", 32'(read_reg_num1), 32'd1);
        check("sub_rs2", 32'(read_reg_num2), 32'd2);
        step(); step();
        check("sub_wb_rw", 32'(reg_write), 32'd1);
        check("sub_wb_rd", 32'(write_reg_num1), 32'd3);
        step();
        check("sub_pc", pc, 32'd8);

        // BEQ x1,x2,+16 taken
        fetch(32'h00208863);
        check("beq_imm", imm_val, 32'd16);
        check("beq_aluctl", 32'(alu_control), 32'h20);
        check("beq_alusrc", 32'(alu_src), 32'd0);
        beq = 1'b1;
        step();
        check("beq_ctl", 32'(beq_control), 32'd1);
        check("beq_exec_rw", 32'(reg_write), 32'd0);
        step();
        beq = 1'b0;
        check("beq_pc", pc, 32'd24);
        check("beq_fetch_rw", 32'(reg_write), 32'd0);
        check("beq_ctl_drop", 32'(beq_control), 32'd0);

        // BNE x1,x2,+16 not taken; beq high must not redirect it
        fetch(32'h00209863);
        beq = 1'b1; bneq = 1'b0;
        step();
        check("bne_ctl", 32'(bne_control), 32'd1);
        check("bne_beqctl", 32'(beq_control), 32'd0);
        step();
        beq = 1'b0;
        check("bne_pc", pc, 32'd28);

        // LW x2,4(x1)
        fetch(32'h0040A103);
        check("lw_alusrc", 32'(alu_src), 32'd1);
        check("lw_imm", imm_val, 32'd4);
        check("lw_rd", 32'(write_reg_num1), 32'd2);
        step(); step();
        check("lw_memread", 32'(mem_read), 32'd1);
        check("lw_memwrite", 32'(mem_write), 32'd0);
        check("lw_mem_rw", 32'(reg_write), 32'd0);
        cnt = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 20 && mem_read; i++) begin
            cnt++;
            if (cnt == 3) mem_ready = 1'b1;
            step();
        end
`ifdef MEM_WAIT_EN
        check("lw_mem_cycles", 32'(cnt), 32'd3);
`else
        check("lw_mem_cycles", 32'(cnt), 32'd1);
`endif
        check("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
        check("lw_wb_rw", 32'(reg_write), 32'd1);
        check("lw_wb_memread", 32'(mem_read), 32'd0);
        step();
        check("lw_pc", pc, 32'd32);
        check("lw_m2r_drop", 32'(mem_to_reg), 32'd0);

        // SW x2,8(x1) completes
        mem_ready = 1'b1;
        fetch(32'h0020A423);
        check("sw_imm", imm_val, 32'd8);
        check("sw_alusrc", 32'(alu_src), 32'd1);
        step(); step();
        check("sw_memwrite", 32'(mem_write), 32'd1);
        check("sw_memread", 32'(mem_read), 32'd0);
        step();
        check("sw_wdrop", 32'(mem_write), 32'd0);
        check("sw_rw", 32'(reg_write), 32'd0);
        check("sw_pc", pc, 32'd36);

        // SW interrupted by reset while in MEM
        mem_ready = 1'b0;
        fetch(32'h0020A423);
        step(); step();
        check("sw2_memwrite", 32'(mem_write), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmem_memwrite", 32'(mem_write), 32'd0);
        check("rstmem_pc", pc, 32'd0);
        check("rstmem_req", 32'(imem_req), 32'd0);
        #3 rst = 1'b1;
        step();
        check("rstmem_req_after", 32'(imem_req), 32'd1);

        // JAL x1,-4 at pc 0
        fetch(32'hFFDFF0EF);
        check("jal_imm", imm_val, 32'hFFFFFFFC);
        check("jal_rd", 32'(write_reg_num1), 32'd1);
        step();
        check("jal_jump", 32'(jump), 32'd1);
        step();
        check("jal_pc", pc, 32'hFFFFFFFC);
        check("jal_link", link_addr, 32'd4);
        check("jal_wb_rw", 32'(reg_write), 32'd1);
        step();
        check("jal_pc_hold", pc, 32'hFFFFFFFC);

        // NOP at 0xFFFFFFFC: rd=0 suppresses write, pc wraps to 0
        fetch(32'h00000013);
        step(); step();
        check("nop_rd0_rw", 32'(reg_write), 32'd0);
        step();
        check("wrap_pc", pc, 32'd0);
        check("wrap_illegal", 32'(illegal), 32'd0);

        // LUI x4,0x12345
        fetch(32'h12345237);
        check("lui_imm_lui", imm_val_lui, 32'h12345000);
        step(); step();
        check("lui_ctl", 32'(lui_control), 32'd1);
        check("lui_rw", 32'(reg_write), 32'd1);
        step();
        check("lui_pc", pc, 32'd4);

        // JALR x5,0(x1) with rs1 result 0x101
        alu_result = 32'h00000101;
        fetch(32'h000082E7);
        check("jalr_alusrc", 32'(alu_src), 32'd1);
        step();
        check("jalr_jump", 32'(jump), 32'd1);
        step();
        check("jalr_pc", pc, 32'h00000100);
        check("jalr_link", link_addr, 32'd8);
        step();

        // Unsupported opcode halts
        fetch(32'h0000007F);
        step();
        check("ill_flag", 32'(illegal), 32'd1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req || reg_write || mem_read || mem_write) hi++;
            step();
        end
        check("ill_quiet", 32'(hi), 32'd0);
        check("ill_sticky", 32'(illegal), 32'd1);
        check("ill_pc", pc, 32'h00000100);
        rst = 1'b0;
        #1;
        check("ill_rst_clear", 32'(illegal), 32'd0);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
